parity_frame_rx: RTL and testbench
==================================

Name: parity_frame_rx

Overview:
Serial receiver for parity-protected frames. It is the checking end of the team's XOR parity generator. It deserializes one frame from a single serial line: start bit, DATA_BITS data bits LSB first, one parity bit, one stop bit. It recomputes the XOR parity, flags parity, framing and overrun errors, and presents the word through a valid/ready handshake to downstream logic.

Parameters:
DATA_BITS, 8, number of data bits per frame (1..16).
CLKS_PER_BIT, 4, clock cycles per serial bit; even, >= 2.
PARITY_ODD, 0, 0 = even parity (XOR of data and parity bit must be 0); 1 = odd parity (must be 1).

Ports:
clk  input  1  system clock, all logic on rising edge.
rst  input  1  synchronous, active-high reset.
rx  input  1  serial line. Idles high. Synchronous to clk; no synchronizer inside the block.
out_data  output  DATA_BITS  received word, bit 0 = first data bit received.
out_valid  output  1  out_data and the error flags are valid.
out_ready  input  1  consumer accepts the word when out_valid && out_ready.
parity_err  output  1  parity check failed for the presented word.
frame_err  output  1  stop bit sampled as 0 for the presented word.
overrun  output  1  the presented word overwrote an unaccepted word.
busy  output  1  a frame is in progress (state != IDLE).

Behaviour:
- Reset: state=IDLE, bit counter=0, clock counter=0, shift register=0. out_data=0, out_valid=0, parity_err=0, frame_err=0, overrun=0, busy=0. Reset mid-frame discards the partial frame and also clears any pending out_valid.
- States: IDLE, START, DATA, PARITY, STOP.
- Clock counter cnt: counts 0..CLKS_PER_BIT-1. A "sample" happens when cnt hits its terminal value; cnt then returns to 0.
- IDLE: when rx==0, go to START with cnt=0. When rx==1, stay.
- START: terminal is CLKS_PER_BIT/2-1 (mid start bit).
  - rx==0 at the sample: go to DATA, bit index=0.
  - rx==1 at the sample: glitch; return to IDLE with no output change.
- DATA: terminal is CLKS_PER_BIT-1. Shift rx into shift register position [bit index]. After bit index DATA_BITS-1, go to PARITY.
- PARITY: terminal is CLKS_PER_BIT-1. Latch rx as the received parity bit, then go to STOP.
- STOP: terminal is CLKS_PER_BIT-1. At the stop sample, in the same edge:
  - out_data <= shift register.
  - parity_err <= (XOR of all data bits ^ parity bit) != PARITY_ODD.
  - frame_err <= ~rx.
  - overrun <= out_valid && !out_ready.
  - out_valid <= 1.
  - State returns to IDLE.
- Latency: out_valid rises on the edge of the stop sample. That edge falls (CLKS_PER_BIT/2) + (DATA_BITS+2)*CLKS_PER_BIT cycles after the IDLE edge that saw rx==0. With the defaults that is 42 cycles.
- Handshake:
  - out_valid stays high, with out_data and the flags stable, until a cycle with out_ready==1. On that edge out_valid <= 0.
  - The flags are cleared only when a new word replaces them or on reset.
  - If a new frame completes on the same edge as a handshake, the new word wins: out_valid stays 1 and overrun=0.
  - If a new frame completes while out_valid && !out_ready, the new word overwrites the old one and overrun=1.
- Back-to-back frames: the next start bit may begin in the cycle immediately after the stop sample. IDLE checks rx starting on that next edge.
- A frame with frame_err=1 is still delivered. There is no break detection or resynchronization beyond returning to IDLE.
- busy = (state != IDLE), registered with the state.

Test Plan:
- Reset, then hold rx=1 for 100 cycles -> out_valid and busy stay 0; all outputs 0.
- Defaults (8, 4, even). Send 0xA5 LSB first, parity 0, stop 1 -> out_valid 42 cycles after the start edge, out_data=0xA5, parity_err=0, frame_err=0. Assert out_ready for 1 cycle -> out_valid=0.
- Send 0xA5 with parity 1 -> parity_err=1, out_data=0xA5. Repeat with PARITY_ODD=1 and parity 1 -> parity_err=0.
- Send 0x3C with stop bit 0 -> frame_err=1, parity_err=0, out_valid=1.
- Drive rx low for 1 cycle, then high -> START aborts at mid-bit, returns to IDLE; out_valid stays 0.
- Send 0x11 with out_ready=0, then 0x22 back-to-back -> out_data=0x22, overrun=1. Handshake, then 0x33 with out_ready=1 -> overrun=0. Separately, assert rst during DATA -> all outputs 0, busy=0; a following 0x5A frame is received correctly.

Source files
------------

// File: rtl/parity_frame_rx.sv
// parity_frame_rx
// ---------------------------------------------------------------------------
// Serial receiver for XOR-parity protected frames. One frame on rx is:
//   start bit (0), DATA_BITS data bits LSB first, one parity bit, stop bit (1).
// The word and its error flags are presented on a valid/ready output port.
//
// Output handshake: out_data, parity_err, frame_err and overrun are valid
// while out_valid is high and hold steady until a clock edge on which
// out_valid && out_ready is true (the word is consumed on that edge). A new
// word completing on any edge replaces the presented word. If that word was
// still unaccepted at that edge, overrun is raised with the new word.
//
// Ports
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   rx          serial line, idles high, already synchronous to clk
//   out_data    received word, bit 0 = first data bit received
//   out_valid   out_data and flags are valid
//   out_ready   consumer accepts the word when out_valid && out_ready
//   parity_err  parity check failed for the presented word
//   frame_err   stop bit sampled as 0 for the presented word
//   overrun     presented word overwrote an unaccepted word
//   busy        a frame is in progress (state != IDLE)
//   dbg_state   current FSM state encoding (IDLE=0 START=1 DATA=2 PARITY=3 STOP=4)
// ---------------------------------------------------------------------------
module parity_frame_rx #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy,
  output logic [2:0]           dbg_state
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [CW-1:0] START_TERM = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_TERM   = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT   = BW'(DATA_BITS - 1);
  localparam logic          PAR_REF    = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t               state;
  logic [CW-1:0]        cnt;
  logic [BW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 par_bit;
  logic                 sample;

  // START samples at mid start bit; every later bit is sampled one full bit
  // period after the previous sample, which keeps subsequent samples mid-bit.
  always_comb begin
    sample = 1'b0;
    if (state == START) sample = (cnt == START_TERM);
    else                sample = (cnt == BIT_TERM);
  end

  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shift_reg  <= '0;
      par_bit    <= 1'b0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      // Consumption first; a word completing on this same edge overrides it.
      if (out_valid && out_ready) out_valid <= 1'b0;

      case (state)
        IDLE: begin
          cnt <= '0;
          if (!rx) begin
            state <= START;
            busy  <= 1'b1;
          end
        end

        START: begin
          if (sample) begin
            cnt <= '0;
            if (!rx) begin
              state   <= DATA;
              bit_idx <= '0;
            end else begin
              // Low pulse shorter than half a bit: treat as a glitch.
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        DATA: begin
          if (sample) begin
            cnt                <= '0;
            shift_reg[bit_idx] <= rx;
            if (bit_idx == LAST_BIT) state <= PARITY;
            else                     bit_idx <= bit_idx + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        PARITY: begin
          if (sample) begin
            cnt     <= '0;
            par_bit <= rx;
            state   <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        STOP: begin
          if (sample) begin
            cnt        <= '0;
            out_data   <= shift_reg;
            parity_err <= ((^shift_reg) ^ par_bit) != PAR_REF;
            frame_err  <= ~rx;
            overrun    <= out_valid && !out_ready;
            out_valid  <= 1'b1;
            state      <= IDLE;
            busy       <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: begin
          state <= IDLE;
          cnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_parity_frame_rx.sv
module tb_parity_frame_rx;

  localparam int DW  = 8;
  localparam int CPB = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx  = 1'b1;
  logic out_ready = 1'b0;

  always #5 clk = ~clk;

  // even-parity instance (defaults)
  logic [DW-1:0] out_data;
  logic          out_valid, parity_err, frame_err, overrun, busy;
  logic [2:0]    dbg_state;

  // odd-parity instance on the same line
  logic [DW-1:0] o_data;
  logic          o_valid, o_perr, o_ferr, o_ovr, o_busy;
  logic [2:0]    o_dbg;

  parity_frame_rx #(.DATA_BITS(DW), .CLKS_PER_BIT(CPB), .PARITY_ODD(0)) dut (
    .clk(clk), .rst(rst), .rx(rx),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .parity_err(parity_err), .frame_err(frame_err), .overrun(overrun),
    .busy(busy), .dbg_state(dbg_state)
  );

  parity_frame_rx #(.DATA_BITS(DW), .CLKS_PER_BIT(CPB), .PARITY_ODD(1)) dut_odd (
    .clk(clk), .rst(rst), .rx(rx),
    .out_data(o_data), .out_valid(o_valid), .out_ready(out_ready),
    .parity_err(o_perr), .frame_err(o_ferr), .overrun(o_ovr),
    .busy(o_busy), .dbg_state(o_dbg)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drives one full frame starting right after an edge. lat returns the
  // index of the first edge (0 = edge that first sees the start bit) after
  // which out_valid reads 1, or -1 if it never did.
  task automatic send_frame(input logic [DW-1:0] d, input logic p,
                            input logic s, output int lat);
    logic [DW+2:0] bits;
    int e;
    bits = {s, p, d, 1'b0};
    lat  = -1;
    e    = 0;
    for (int b = 0; b < DW + 3; b++) begin
      rx = bits[b];
      for (int c = 0; c < CPB; c++) begin
        @(posedge clk);
        #1;
        if (lat < 0 && out_valid === 1'b1) lat = e;
        e++;
      end
    end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    tick(1);
    out_ready = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL handshake_clear: out_valid=%b expected 0", out_valid);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    rx = 1'b1;
    out_ready = 1'b0;
    tick(3);
    rst = 1'b0;
    n_cmp++;
    if ({out_data, out_valid, parity_err, frame_err, overrun, busy} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: data=%h v=%b pe=%b fe=%b ov=%b busy=%b expected all 0",
               out_data, out_valid, parity_err, frame_err, overrun, busy);
    end
    for (int i = 0; i < 100; i++) begin
      tick(1);
      n_cmp++;
      if ({out_data, out_valid, parity_err, frame_err, overrun, busy} !== '0) begin
        n_fail++;
        $display("FAIL idle_hold cycle %0d: data=%h v=%b busy=%b expected 0", i, out_data,
                 out_valid, busy);
      end
    end
  endtask

  task automatic test_basic();
    int lat;
    send_frame(8'hA5, 1'b0, 1'b1, lat);
    n_cmp++;
    if (lat !== 42) begin
      n_fail++;
      $display("FAIL basic_latency: got %0d expected 42", lat);
    end
    n_cmp++;
    if (out_data !== 8'hA5) begin
      n_fail++;
      $display("FAIL basic_data: got %h expected a5", out_data);
    end
    n_cmp++;
    if ({out_valid, parity_err, frame_err, overrun} !== 4'b1000) begin
      n_fail++;
      $display("FAIL basic_flags: v/pe/fe/ov=%b expected 1000",
               {out_valid, parity_err, frame_err, overrun});
    end
    tick(3);
    n_cmp++;
    if (out_valid !== 1'b1 || out_data !== 8'hA5) begin
      n_fail++;
      $display("FAIL basic_hold: v=%b data=%h expected 1 a5", out_valid, out_data);
    end
    handshake();
  endtask

  task automatic test_parity();
    int lat;
    send_frame(8'hA5, 1'b1, 1'b1, lat);
    n_cmp++;
    if (parity_err !== 1'b1 || out_data !== 8'hA5) begin
      n_fail++;
      $display("FAIL parity_even_bad: pe=%b data=%h expected 1 a5", parity_err, out_data);
    end
    n_cmp++;
    if (o_perr !== 1'b0 || o_data !== 8'hA5 || o_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL parity_odd_good: pe=%b data=%h v=%b expected 0 a5 1", o_perr, o_data,
               o_valid);
    end
    handshake();
  endtask

  task automatic test_frame_err();
    int lat;
    send_frame(8'h3C, 1'b0, 1'b0, lat);
    n_cmp++;
    if ({out_valid, frame_err, parity_err} !== 3'b110 || out_data !== 8'h3C) begin
      n_fail++;
      $display("FAIL frame_err: v/fe/pe=%b data=%h expected 110 3c",
               {out_valid, frame_err, parity_err}, out_data);
    end
    rx = 1'b1;
    tick(8);
    handshake();
  endtask

  task automatic test_glitch();
    rx = 1'b0;
    tick(1);
    rx = 1'b1;
    n_cmp++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL glitch_start: busy=%b expected 1", busy);
    end
    tick(2);
    n_cmp++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL glitch_abort: busy=%b v=%b expected 0 0", busy, out_valid);
    end
    tick(50);
    n_cmp++;
    if (out_valid !== 1'b0 || dbg_state !== 3'd0) begin
      n_fail++;
      $display("FAIL glitch_quiet: v=%b state=%0d expected 0 0", out_valid, dbg_state);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    out_ready = 1'b0;
    send_frame(8'h11, 1'b0, 1'b1, lat);
    send_frame(8'h22, 1'b0, 1'b1, lat);
    n_cmp++;
    if (out_data !== 8'h22 || {out_valid, overrun, parity_err} !== 3'b110) begin
      n_fail++;
      $display("FAIL overrun_set: data=%h v/ov/pe=%b expected 22 110", out_data,
               {out_valid, overrun, parity_err});
    end
    handshake();
    out_ready = 1'b1;
    send_frame(8'h33, 1'b0, 1'b1, lat);
    n_cmp++;
    if (out_data !== 8'h33 || overrun !== 1'b0 || parity_err !== 1'b0) begin
      n_fail++;
      $display("FAIL overrun_clear: data=%h ov=%b pe=%b expected 33 0 0", out_data, overrun,
               parity_err);
    end
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL ready_consume: v=%b expected 0", out_valid);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_rst_mid_frame();
    int lat;
    send_frame(8'h44, 1'b0, 1'b1, lat);
    // partial frame: start bit plus three data bits of 0x5A
    rx = 1'b0;
    tick(CPB);
    rx = 1'b0; tick(CPB);
    rx = 1'b1; tick(CPB);
    rx = 1'b0; tick(CPB);
    n_cmp++;
    if (busy !== 1'b1 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset: busy=%b v=%b expected 1 1", busy, out_valid);
    end
    rst = 1'b1;
    rx = 1'b1;
    tick(1);
    rst = 1'b0;
    n_cmp++;
    if ({out_data, out_valid, parity_err, frame_err, overrun, busy} !== '0) begin
      n_fail++;
      $display("FAIL mid_reset: data=%h v=%b pe=%b fe=%b ov=%b busy=%b expected all 0",
               out_data, out_valid, parity_err, frame_err, overrun, busy);
    end
    tick(5);
    send_frame(8'h5A, 1'b0, 1'b1, lat);
    n_cmp++;
    if (lat !== 42 || out_data !== 8'h5A) begin
      n_fail++;
      $display("FAIL post_reset_rx: lat=%0d data=%h expected 42 5a", lat, out_data);
    end
    n_cmp++;
    if ({out_valid, parity_err, frame_err, overrun} !== 4'b1000) begin
      n_fail++;
      $display("FAIL post_reset_flags: v/pe/fe/ov=%b expected 1000",
               {out_valid, parity_err, frame_err, overrun});
    end
    handshake();
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_frame_err();
    test_glitch();
    test_back_to_back();
    test_rst_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

endmodule
